hue_sequencer: RTL and testbench
================================

# hue_sequencer

Controller that sequences the three colour-channel PWM generators of the RGB LED through a continuous hue wheel. It steps a level counter at a programmable rate and walks a 6-segment state machine. Each cycle it presents registered red/green/blue duty cycles in the 0..100 range expected by the `pwm` instances. It sits between the top level and the three `pwm` blocks and is their only source of `duty_cycle`.

## Interface
- `TICKS_PER_LEVEL`, default 20000: enabled clock cycles per level step. Must be ≥1. At 12 MHz the default gives exactly 1 s per full hue cycle (6 × 100 × 20000).
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `rst` input, 1 bit: reset. One clock; reset is synchronous and active-high.
- `enable` input, 1 bit: advance when high; freeze all state when low.
- `restart` input, 1 bit: synchronous single-cycle request to return to hue start.
- `red_duty` output, 32 bits (`integer`): duty for red `pwm`, 0..100.
- `green_duty` output, 32 bits (`integer`): duty for green `pwm`, 0..100.
- `blue_duty` output, 32 bits (`integer`): duty for blue `pwm`, 0..100.
- `segment` output, 3 bits: current segment, 0..5.
- `wrap` output, 1 bit: one-cycle pulse when segment 5 rolls over to segment 0.

## Operation
- State: prescaler `0..TICKS_PER_LEVEL-1`, level `0..99`, segment `0..5`.
- Tick is asserted when `enable` is high and the prescaler equals `TICKS_PER_LEVEL-1`. On a tick, the prescaler returns to 0. Otherwise, when enabled, the prescaler increments.
- On a tick:
  - If level < 99, level increments.
  - Otherwise level goes to 0 and the segment advances (0→1→…→5→0).
- Segment FSM, with L = level:
  - SEG_G_UP (0): R=100, G=L, B=0.
  - SEG_R_DN (1): R=100−L, G=100, B=0.
  - SEG_B_UP (2): R=0, G=100, B=L.
  - SEG_G_DN (3): R=0, G=100−L, B=100.
  - SEG_R_UP (4): R=L, G=0, B=100.
  - SEG_B_DN (5): R=100, G=0, B=100−L.
- Hue is continuous across boundaries with no repeated triple. A full cycle is 600 distinct levels.
- Segment encodings 6 and 7 are unreachable. If ever entered, the next edge forces segment 0, level 0.
- `enable` low: prescaler, level, segment and outputs hold. `restart` and `rst` still act.
- Priority: `rst` > `restart` > tick.
- `restart` sets prescaler 0, level 0, segment 0 and `wrap` 0. It is honoured regardless of `enable`.
- Invariant: at every cycle at least one duty equals 100 and at least one equals 0.
- Arithmetic: level math is 7-bit unsigned. Outputs are zero-extended to 32 bits, never negative.

## Timing
- Reset values (edge with `rst` high): prescaler 0, level 0, segment 0, `red_duty`=100, `green_duty`=0, `blue_duty`=0, `wrap`=0.
- Duty outputs and `segment` are registered. They are computed from the next level/segment, so they change on the same edge as the level register, with zero extra latency after a tick.
- From reset release with `enable` held high, the first output change occurs on the `TICKS_PER_LEVEL`-th enabled rising edge.
- `wrap` is high for exactly the one cycle following the edge on which segment 5 → 0. It is cleared on the next edge, even if `enable` drops.
- With `TICKS_PER_LEVEL`=1, a tick occurs on every enabled cycle and the level steps every edge.
- `rst` or `restart` mid-level discards the partial prescaler count.

## Structure
- Shared package `pwm_pkg` contains:
  - `DUTY_MAX` = 100.
  - `LEVELS_PER_SEG` = 100.
  - `typedef enum logic [2:0] segment_t` {SEG_G_UP, SEG_R_DN, SEG_B_UP, SEG_G_DN, SEG_R_UP, SEG_B_DN}.
- Sub-module `tick_gen` holds the prescaler.
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: one-cycle `tick`.
  - Parameter: `TICKS_PER_LEVEL`.
- `hue_sequencer` holds the level counter, the segment FSM and the output registers.

## Test plan
All scenarios use `TICKS_PER_LEVEL`=4 unless stated otherwise.
- **Reset:** `rst` high 2 cycles → R/G/B = 100/0/0, `segment`=0, `wrap`=0. Then `enable` low for 50 cycles → outputs unchanged.
- **Ramp:** `enable` high from reset release.
  - Green = 1 after edge 4, 2 after edge 8, 99 after edge 396.
  - After edge 400: R/G/B = 100/100/0, `segment`=1.
  - After edge 404: R=99.
- **Full wheel:** 2400 enabled edges → `wrap` high for exactly 1 cycle right after edge 2400, R/G/B = 100/0/0, `segment`=0. No other `wrap` pulse occurs. The bench checks the invariant on every cycle.
- **Freeze:** drop `enable` for 10 cycles after 2 cycles of a level → outputs are frozen. Re-enable → next step occurs exactly 2 enabled cycles later.
- **Restart:** pulse `restart` in segment 3 with `enable` low → next edge R/G/B = 100/0/0, `segment`=0, prescaler cleared. With `rst` and `restart` both high, the reset values apply.
- **Fast and mid-op reset:** with `TICKS_PER_LEVEL`=1, the level steps every cycle, so segment 4 is reached after 400 edges. Asserting `rst` there gives 100/0/0 on the next edge.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the RGB hue sequencer and its pwm consumers.
package pwm_pkg;

    localparam logic [6:0] DUTY_MAX       = 7'd100;
    localparam logic [6:0] LEVELS_PER_SEG = 7'd100;
    localparam logic [6:0] LEVEL_LAST     = 7'd99;

    typedef enum logic [2:0] {
        SEG_G_UP = 3'd0,
        SEG_R_DN = 3'd1,
        SEG_B_UP = 3'd2,
        SEG_G_DN = 3'd3,
        SEG_R_UP = 3'd4,
        SEG_B_DN = 3'd5
    } segment_t;

    // Falling channel value for a level: full scale minus the level.
    function automatic logic [6:0] duty_inv(input logic [6:0] level);
        return DUTY_MAX - level;
    endfunction

    // Successor on the hue wheel; anything unexpected restarts at the first segment.
    function automatic segment_t seg_succ(input segment_t seg);
        segment_t nxt;
        case (seg)
            SEG_G_UP: nxt = SEG_R_DN;
            SEG_R_DN: nxt = SEG_B_UP;
            SEG_B_UP: nxt = SEG_G_DN;
            SEG_G_DN: nxt = SEG_R_UP;
            SEG_R_UP: nxt = SEG_B_DN;
            SEG_B_DN: nxt = SEG_G_UP;
            default:  nxt = SEG_G_UP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hue_sequencer_if.sv
// Control and duty-cycle bundle between the top level and the hue sequencer.
interface hue_sequencer_if;
    logic        enable;
    logic        restart;
    logic [31:0] red_duty;
    logic [31:0] green_duty;
    logic [31:0] blue_duty;
    logic [2:0]  segment;
    logic        wrap;

    modport master (
        output enable, restart,
        input  red_duty, green_duty, blue_duty, segment, wrap
    );

    modport slave (
        input  enable, restart,
        output red_duty, green_duty, blue_duty, segment, wrap
    );
endinterface

// File: rtl/hue_sequencer_tick_gen.sv
// Prescaler producing one level-step tick every TICKS_PER_LEVEL enabled cycles.
module tick_gen #(
    parameter int TICKS_PER_LEVEL = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (TICKS_PER_LEVEL > 1) ? $clog2(TICKS_PER_LEVEL) : 1;
    localparam logic [PW-1:0] LAST  = PW'(TICKS_PER_LEVEL - 1);
    localparam logic [PW-1:0] ONE   = PW'(1);
    localparam logic [PW-1:0] ZERO  = PW'(0);

    logic [PW-1:0] r_prescaler;

    // Tick fires from the registered count so the level moves on the same edge.
    assign tick = enable && (r_prescaler == LAST);

    // Prescaler: cleared by reset/restart, wraps on tick, holds while disabled.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_prescaler <= ZERO;
        end else if (tick) begin
            r_prescaler <= ZERO;
        end else if (enable) begin
            r_prescaler <= r_prescaler + ONE;
        end else begin
            r_prescaler <= r_prescaler;
        end
    end

endmodule

// File: rtl/hue_sequencer.sv
// Walks the six-segment hue wheel and drives registered R/G/B duty cycles.
module hue_sequencer
    import pwm_pkg::*;
#(
    parameter int TICKS_PER_LEVEL = 20000
) (
    input  logic            clk,
    input  logic            rst,
    hue_sequencer_if.slave  bus
);

    logic       w_tick;
    logic [6:0] r_level;
    segment_t   r_segment;
    logic       r_wrap;
    logic [6:0] r_red;
    logic [6:0] r_green;
    logic [6:0] r_blue;

    logic [6:0] w_level_next;
    segment_t   w_segment_next;
    logic       w_wrap_next;
    logic [6:0] w_red_next;
    logic [6:0] w_green_next;
    logic [6:0] w_blue_next;

    tick_gen #(
        .TICKS_PER_LEVEL (TICKS_PER_LEVEL)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.restart),
        .enable (bus.enable),
        .tick   (w_tick)
    );

    // State and output registers; duties are loaded from the next-state view.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level   <= 7'd0;
            r_segment <= SEG_G_UP;
            r_wrap    <= 1'b0;
            r_red     <= DUTY_MAX;
            r_green   <= 7'd0;
            r_blue    <= 7'd0;
        end else begin
            r_level   <= w_level_next;
            r_segment <= w_segment_next;
            r_wrap    <= w_wrap_next;
            r_red     <= w_red_next;
            r_green   <= w_green_next;
            r_blue    <= w_blue_next;
        end
    end

    // Next level/segment: restart first, then illegal-state recovery, then tick stepping.
    always_comb begin
        w_level_next   = r_level;
        w_segment_next = r_segment;
        w_wrap_next    = 1'b0;
        if (bus.restart) begin
            w_level_next   = 7'd0;
            w_segment_next = SEG_G_UP;
        end else begin
            case (r_segment)
                SEG_G_UP, SEG_R_DN, SEG_B_UP, SEG_G_DN, SEG_R_UP, SEG_B_DN: begin
                    if (w_tick) begin
                        if (r_level < LEVEL_LAST) begin
                            w_level_next = r_level + 7'd1;
                        end else begin
                            w_level_next   = 7'd0;
                            w_segment_next = seg_succ(r_segment);
                            w_wrap_next    = (r_segment == SEG_B_DN);
                        end
                    end else begin
                        w_level_next   = r_level;
                        w_segment_next = r_segment;
                    end
                end
                default: begin
                    w_level_next   = 7'd0;
                    w_segment_next = SEG_G_UP;
                end
            endcase
        end
    end

    // Duty mapping for the upcoming level/segment so outputs carry no extra latency.
    always_comb begin
        w_red_next   = DUTY_MAX;
        w_green_next = 7'd0;
        w_blue_next  = 7'd0;
        case (w_segment_next)
            SEG_G_UP: begin
                w_red_next = DUTY_MAX;               w_green_next = w_level_next;            w_blue_next = 7'd0;
            end
            SEG_R_DN: begin
                w_red_next = duty_inv(w_level_next); w_green_next = DUTY_MAX;                w_blue_next = 7'd0;
            end
            SEG_B_UP: begin
                w_red_next = 7'd0;                   w_green_next = DUTY_MAX;                w_blue_next = w_level_next;
            end
            SEG_G_DN: begin
                w_red_next = 7'd0;                   w_green_next = duty_inv(w_level_next);  w_blue_next = DUTY_MAX;
            end
            SEG_R_UP: begin
                w_red_next = w_level_next;           w_green_next = 7'd0;                    w_blue_next = DUTY_MAX;
            end
            SEG_B_DN: begin
                w_red_next = DUTY_MAX;               w_green_next = 7'd0;                    w_blue_next = duty_inv(w_level_next);
            end
            default: begin
                w_red_next = DUTY_MAX;               w_green_next = 7'd0;                    w_blue_next = 7'd0;
            end
        endcase
    end

    assign bus.red_duty   = {25'd0, r_red};
    assign bus.green_duty = {25'd0, r_green};
    assign bus.blue_duty  = {25'd0, r_blue};
    assign bus.segment    = r_segment;
    assign bus.wrap       = r_wrap;

endmodule

// File: tb/tb_hue_sequencer.sv
// Directed, table-driven bench for hue_sequencer (TICKS_PER_LEVEL=4 and =1).
module tb_hue_sequencer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hue_sequencer_if bus_a ();
    hue_sequencer_if bus_b ();

    hue_sequencer #(.TICKS_PER_LEVEL(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    hue_sequencer #(.TICKS_PER_LEVEL(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    typedef struct {
        string name;
        int    n;
        logic  en;
        logic  rs;
        logic  rst;
        int    r;
        int    g;
        int    b;
        int    seg;
        logic  wr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string name, input int n, input logic en, input logic rs,
                                input logic rst, input int r, input int g, input int b,
                                input int seg, input logic wr);
        vec_t v;
        v.name = name; v.n = n; v.en = en; v.rs = rs; v.rst = rst;
        v.r = r; v.g = g; v.b = b; v.seg = seg; v.wr = wr;
        return v;
    endfunction

    task automatic check(input string nm, input int r, input int g, input int b, input int seg,
                         input logic wr, input logic [31:0] ar, input logic [31:0] ag,
                         input logic [31:0] ab, input logic [2:0] aseg, input logic awr);
        checks++;
        if (ar !== r || ag !== g || ab !== b || aseg !== seg || awr !== wr) begin
            errors++;
            $display("FAIL %s: got R/G/B=%0d/%0d/%0d seg=%0d wrap=%0b, want %0d/%0d/%0d seg=%0d wrap=%0b",
                     nm, ar, ag, ab, aseg, awr, r, g, b, seg, wr);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rst_a         = vq[i].rst;
            bus_a.enable  = vq[i].en;
            bus_a.restart = vq[i].rs;
            repeat (vq[i].n) @(posedge clk);
            @(negedge clk);
            check(vq[i].name, vq[i].r, vq[i].g, vq[i].b, vq[i].seg, vq[i].wr,
                  bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
        end
    endtask

    initial begin
        int wraps;
        logic has_max;
        logic has_zero;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.enable = 1'b0; bus_a.restart = 1'b0;
        bus_b.enable = 1'b0; bus_b.restart = 1'b0;

        // Reset and ramp up to edge 404 (indices 0..7)
        vq.push_back(mk("reset",        2, 1'b0, 1'b0, 1'b1, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("idle_hold",   50, 1'b0, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("pre_tick",     3, 1'b1, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("edge4",        1, 1'b1, 1'b0, 1'b0, 100,   1,   0, 0, 1'b0));
        vq.push_back(mk("edge8",        4, 1'b1, 1'b0, 1'b0, 100,   2,   0, 0, 1'b0));
        vq.push_back(mk("edge396",    388, 1'b1, 1'b0, 1'b0, 100,  99,   0, 0, 1'b0));
        vq.push_back(mk("edge400",      4, 1'b1, 1'b0, 1'b0, 100, 100,   0, 1, 1'b0));
        vq.push_back(mk("edge404",      4, 1'b1, 1'b0, 1'b0,  99, 100,   0, 1, 1'b0));
        // Freeze, restart and reset priority after the full wheel (indices 8..19)
        vq.push_back(mk("lvl_2cyc",     1, 1'b1, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("frozen",      10, 1'b0, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("reen_1",       1, 1'b1, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("reen_2",       1, 1'b1, 1'b0, 1'b0, 100,   1,   0, 0, 1'b0));
        vq.push_back(mk("restart_en",   1, 1'b1, 1'b1, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("to_seg3",   1208, 1'b1, 1'b0, 1'b0,   0,  98, 100, 3, 1'b0));
        vq.push_back(mk("seg3_part",    2, 1'b1, 1'b0, 1'b0,   0,  98, 100, 3, 1'b0));
        vq.push_back(mk("restart_dis",  1, 1'b0, 1'b1, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("psc_clr_3",    3, 1'b1, 1'b0, 1'b0, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("psc_clr_4",    1, 1'b1, 1'b0, 1'b0, 100,   1,   0, 0, 1'b0));
        vq.push_back(mk("rst_and_rs",   1, 1'b1, 1'b1, 1'b1, 100,   0,   0, 0, 1'b0));
        vq.push_back(mk("post_rst",     4, 1'b1, 1'b0, 1'b0, 100,   1,   0, 0, 1'b0));

        run_vecs(0, 7);

        // Full wheel: edges 405..2401, invariant every cycle, exactly one wrap
        wraps = 0;
        for (int e = 405; e <= 2401; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_a.wrap) wraps++;
            has_max  = (bus_a.red_duty == 100) || (bus_a.green_duty == 100) || (bus_a.blue_duty == 100);
            has_zero = (bus_a.red_duty == 0)   || (bus_a.green_duty == 0)   || (bus_a.blue_duty == 0);
            checks++;
            if (!has_max || !has_zero || bus_a.red_duty > 100 || bus_a.green_duty > 100 ||
                bus_a.blue_duty > 100 || bus_a.segment > 3'd5) begin
                errors++;
                $display("FAIL invariant edge %0d: got R/G/B=%0d/%0d/%0d seg=%0d, want one 100 and one 0",
                         e, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment);
            end
            case (e)
                1000: check("edge1000", 0, 100, 50, 2, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                1400: check("edge1400", 0, 50, 100, 3, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                1800: check("edge1800", 50, 0, 100, 4, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                2200: check("edge2200", 100, 0, 50, 5, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                2399: check("edge2399", 100, 0, 1, 5, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                2400: check("edge2400_wrap", 100, 0, 0, 0, 1'b1, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                2401: check("edge2401", 100, 0, 0, 0, 1'b0, bus_a.red_duty, bus_a.green_duty, bus_a.blue_duty, bus_a.segment, bus_a.wrap);
                default: ;
            endcase
        end
        checks++;
        if (wraps != 1) begin
            errors++;
            $display("FAIL wrap_count: got %0d pulses, want 1", wraps);
        end

        run_vecs(8, 19);

        // Fast instance: one level per edge, reset while in segment 4
        rst_b = 1'b0;
        bus_b.enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("fast_edge1", 100, 1, 0, 0, 1'b0, bus_b.red_duty, bus_b.green_duty, bus_b.blue_duty, bus_b.segment, bus_b.wrap);
        repeat (399) @(posedge clk);
        @(negedge clk);
        check("fast_edge400", 0, 0, 100, 4, 1'b0, bus_b.red_duty, bus_b.green_duty, bus_b.blue_duty, bus_b.segment, bus_b.wrap);
        rst_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("fast_rst", 100, 0, 0, 0, 1'b0, bus_b.red_duty, bus_b.green_duty, bus_b.blue_duty, bus_b.segment, bus_b.wrap);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
